// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, masters the bus for one word per transaction, and
// fills the IF/ID register. Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter int unsigned          ADDR_W   = 30,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [DATA_W-1:0]    NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en,
  output logic              if_busy,
  output logic              bus_req_,
  input  logic              bus_grant_,
  output logic              bus_as_,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StAccess} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [DATA_W-1:0]   if_insn_q, if_insn_d;
  logic                if_en_q, if_en_d;
  logic                if_busy_q, if_busy_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0]   hold_insn_q, hold_insn_d;
  logic                discard_q, discard_d;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                complete;
  logic                accept;

  always_comb begin
    // A taken branch only counts when decode is not stalled; flush always wins.
    redirect    = flush | (br_taken & ~stall);
    redirect_pc = flush ? new_pc : br_addr;
    complete    = (state_q == StAccess) & ~bus_rdy_;
    accept      = complete & ~discard_q & ~redirect;

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    if_pc_d      = if_pc_q;
    if_insn_d    = if_insn_q;
    if_en_d      = if_en_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_insn_d  = hold_insn_q;
    discard_d    = discard_q;
    bus_addr_d   = bus_addr_q;

    unique case (state_q)
      StIdle: begin
        if (!hold_valid_q && !redirect) state_d = StReq;
      end
      StReq: begin
        if (redirect)         state_d = StIdle;
        else if (!bus_grant_) state_d = StAccess;
      end
      StAccess: begin
        // A redirected transaction must still run to completion on the bus.
        if (complete) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      fetch_pc_d   = redirect_pc;
      if_en_d      = 1'b0;
      if_insn_d    = NOP_INSN;
      hold_valid_d = 1'b0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (stall) begin
        if (accept) begin
          hold_valid_d = 1'b1;
          hold_pc_d    = fetch_pc_q;
          hold_insn_d  = bus_rd_data;
        end
      end else if (hold_valid_q) begin
        if_en_d      = 1'b1;
        if_pc_d      = hold_pc_q;
        if_insn_d    = hold_insn_q;
        hold_valid_d = 1'b0;
      end else if (accept) begin
        if_en_d   = 1'b1;
        if_pc_d   = fetch_pc_q;
        if_insn_d = bus_rd_data;
      end else begin
        if_en_d   = 1'b0;
        if_insn_d = NOP_INSN;
      end
    end

    if (state_q == StReq && state_d == StAccess) bus_addr_d = fetch_pc_q;
    bus_req_d = (state_d == StIdle);
    bus_as_d  = (state_d != StAccess);
    if_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      if_pc_q      <= RESET_PC;
      if_insn_q    <= NOP_INSN;
      if_en_q      <= 1'b0;
      if_busy_q    <= 1'b0;
      bus_req_q    <= 1'b1;
      bus_as_q     <= 1'b1;
      bus_addr_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_insn_q  <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      if_pc_q      <= if_pc_d;
      if_insn_q    <= if_insn_d;
      if_en_q      <= if_en_d;
      if_busy_q    <= if_busy_d;
      bus_req_q    <= bus_req_d;
      bus_as_q     <= bus_as_d;
      bus_addr_q   <= bus_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_insn_q  <= hold_insn_d;
      discard_q    <= discard_d;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;
  assign if_busy  = if_busy_q;
  assign bus_req_ = bus_req_q;
  assign bus_as_  = bus_as_q;
  assign bus_addr = bus_addr_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (accept)              perf_fetch_d  = perf_fetch_q + 32'd1;
    if (!stall && !if_en_d)  perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`else
  // No performance counters in this build.
`endif

endmodule
